// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared control-pipeline constants: forwarding selects, aluop and opcode names.
package ctrl_pipe_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// EX-stage operand forwarding select; the EX/MEM result is newer so it wins over MEM/WB.
module fwd_unit
    import ctrl_pipe_hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            i_mem_regwrite,
    input  logic [RA_W-1:0] i_mem_dst,
    input  logic            i_wb_regwrite,
    input  logic [RA_W-1:0] i_wb_dst,
    input  logic [RA_W-1:0] i_ex_rs,
    input  logic [RA_W-1:0] i_ex_rt,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b
);

    logic w_mem_ok;
    logic w_wb_ok;

    assign w_mem_ok = i_mem_regwrite && (i_mem_dst != '0);
    assign w_wb_ok  = i_wb_regwrite && (i_wb_dst != '0);

    always_comb begin
        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        if (w_mem_ok && i_mem_dst == i_ex_rs)
            o_fwd_a = FWD_MEM;
        else if (w_wb_ok && i_wb_dst == i_ex_rs)
            o_fwd_a = FWD_WB;
        if (w_mem_ok && i_mem_dst == i_ex_rt)
            o_fwd_b = FWD_MEM;
        else if (w_wb_ok && i_wb_dst == i_ex_rt)
            o_fwd_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall and MEM-resolved beq flush.
// Define FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise RAW hazards stall.
module ctrl_pipe_hazard
    import ctrl_pipe_hazard_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int AOP_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regdst,
    input  logic             alusrc,
    input  logic             memtoreg,
    input  logic             regwrite,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             branch,
    input  logic [AOP_W-1:0] aluop,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_zero,
    output logic             ex_alusrc,
    output logic [AOP_W-1:0] ex_aluop,
    output logic [RA_W-1:0]  ex_rs,
    output logic [RA_W-1:0]  ex_rt,
    output logic [RA_W-1:0]  ex_dst,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_regwrite,
    output logic [RA_W-1:0]  mem_dst,
    output logic             br_taken,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic [RA_W-1:0]  wb_dst,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic             r_ex_alusrc, r_ex_memtoreg, r_ex_regwrite;
    logic             r_ex_memread, r_ex_memwrite, r_ex_branch;
    logic [AOP_W-1:0] r_ex_aluop;
    logic [RA_W-1:0]  r_ex_rs, r_ex_rt, r_ex_dst;

    logic             r_mem_memtoreg, r_mem_regwrite, r_mem_memread;
    logic             r_mem_memwrite, r_mem_branch, r_mem_zero;
    logic [RA_W-1:0]  r_mem_dst;

    logic             r_wb_regwrite, r_wb_memtoreg;
    logic [RA_W-1:0]  r_wb_dst;

    logic w_ex_hit, w_mem_hit;
    logic w_ld_use, w_raw_stall, w_stall, w_flush;

    // Writer-bit and nonzero-dst qualifiers keep bubbles and $0 writes inert.
    assign w_ex_hit = (r_ex_dst != '0) &&
                      (r_ex_dst == id_rs || r_ex_dst == id_rt);
    assign w_mem_hit = (r_mem_dst != '0) &&
                       (r_mem_dst == id_rs || r_mem_dst == id_rt);
    assign w_ld_use = r_ex_memread && w_ex_hit;

`ifdef FORWARD_EN
    assign w_raw_stall = 1'b0;

    fwd_unit #(.RA_W(RA_W)) u_fwd (
        .i_mem_regwrite (r_mem_regwrite),
        .i_mem_dst      (r_mem_dst),
        .i_wb_regwrite  (r_wb_regwrite),
        .i_wb_dst       (r_wb_dst),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
    );
`else
    assign w_raw_stall = (r_ex_regwrite && w_ex_hit) ||
                         (r_mem_regwrite && w_mem_hit);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign w_stall    = w_ld_use || w_raw_stall;
    assign w_flush    = r_mem_branch && r_mem_zero;
    assign pc_write   = w_flush || !w_stall;
    assign ifid_write = w_flush || !w_stall;
    assign ifid_flush = w_flush;
    assign br_taken   = w_flush;

    always_ff @(posedge clk) begin
        if (rst || w_stall || w_flush) begin
            r_ex_alusrc   <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_branch   <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_dst      <= '0;
        end else begin
            r_ex_alusrc   <= alusrc;
            r_ex_memtoreg <= memtoreg;
            r_ex_regwrite <= regwrite;
            r_ex_memread  <= memread;
            r_ex_memwrite <= memwrite;
            r_ex_branch   <= branch;
            r_ex_aluop    <= aluop;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_dst      <= regdst ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_branch   <= 1'b0;
            r_mem_zero     <= 1'b0;
            r_mem_dst      <= '0;
        end else begin
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_branch   <= r_ex_branch;
            r_mem_zero     <= ex_zero;
            r_mem_dst      <= r_ex_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_dst      <= '0;
        end else begin
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_memtoreg <= r_mem_memtoreg;
            r_wb_dst      <= r_mem_dst;
        end
    end

    assign ex_alusrc    = r_ex_alusrc;
    assign ex_aluop     = r_ex_aluop;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_dst       = r_ex_dst;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_dst      = r_mem_dst;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_dst       = r_wb_dst;

endmodule
